// File: rtl/bayes_seq_scorer.sv
// bayes_seq_scorer: streaming Naive Bayes scoring core.
// Each packet starts with a header beat that gives a word count N. The next
// N beats are word indices. Every index reads one log-weight per class from
// that class's RAM, and the weight is added to the class accumulator with
// saturation. The per-class log-prior is added next. A sequential argmax pass
// then reports the winning class, its score and the best-to-second margin.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/in_data header + word-index stream
//   wr_en/wr_ready/wr_bias/wr_class/wr_addr/wr_data
//                             run-time weight / log-prior load (IDLE only)
//   out_valid/out_ready       result handshake
//   class_win/score_win/margin result (margin unsigned, saturated)
module bayes_seq_scorer #(
  parameter int AMOUNT_CLASS = 4,
  parameter int WIDTH_WORD   = 8,
  parameter int WIDTH_LOG_W  = 16,
  parameter int WIDTH_ACC    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH_WORD-1:0]             in_data,
  input  logic                              wr_en,
  output logic                              wr_ready,
  input  logic                              wr_bias,
  input  logic [$clog2(AMOUNT_CLASS):0]     wr_class,
  input  logic [WIDTH_WORD-1:0]             wr_addr,
  input  logic signed [WIDTH_LOG_W-1:0]     wr_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(AMOUNT_CLASS):0]     class_win,
  output logic signed [WIDTH_ACC-1:0]       score_win,
  output logic [WIDTH_ACC-1:0]              margin
);

  localparam int CW    = $clog2(AMOUNT_CLASS) + 1;
  localparam int DEPTH = 2 ** WIDTH_WORD;

  localparam logic signed [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic signed [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_BIAS,
    S_SCAN,
    S_OUT
  } state_t;

  state_t                         state_q, state_d;
  logic [WIDTH_WORD-1:0]          cnt_q;
  logic [CW-1:0]                  scan_q;
  logic                           rd_vld_q;
  logic signed [WIDTH_ACC-1:0]    best_q, second_q;
  logic [CW-1:0]                  best_idx_q;

  logic                           in_fire, wr_fire, out_fire, word_fire;
  logic signed [WIDTH_ACC-1:0]    acc_all [AMOUNT_CLASS];
  logic signed [WIDTH_ACC-1:0]    cur;
  logic signed [WIDTH_ACC-1:0]    best_d, second_d;
  logic [CW-1:0]                  best_idx_d;
  logic [WIDTH_ACC:0]             diff;
  logic [WIDTH_ACC-1:0]           margin_d;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign wr_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);

  assign in_fire   = in_valid && in_ready;
  assign wr_fire   = wr_en && wr_ready;
  assign out_fire  = out_valid && out_ready;
  assign word_fire = in_fire && (state_q == S_ACCUM);

  // Sign-extend the weight and add it to the accumulator. The sum is clamped
  // to the accumulator range and does not wrap.
  function automatic logic signed [WIDTH_ACC-1:0] sat_add(
    input logic signed [WIDTH_ACC-1:0]   a,
    input logic signed [WIDTH_LOG_W-1:0] b
  );
    logic [WIDTH_ACC:0] s;
    s = {a[WIDTH_ACC-1], a} + {{(WIDTH_ACC+1-WIDTH_LOG_W){b[WIDTH_LOG_W-1]}}, b};
    if (s[WIDTH_ACC] != s[WIDTH_ACC-1])
      sat_add = s[WIDTH_ACC] ? ACC_MIN : ACC_MAX;
    else
      sat_add = s[WIDTH_ACC-1:0];
  endfunction

  for (genvar g = 0; g < AMOUNT_CLASS; g++) begin : g_class
    logic signed [WIDTH_LOG_W-1:0] mem [DEPTH];
    logic signed [WIDTH_LOG_W-1:0] rd;
    logic signed [WIDTH_LOG_W-1:0] prior;
    logic signed [WIDTH_ACC-1:0]   acc;
    logic                          hit;

    assign hit = (wr_class == CW'(g));

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
      if (wr_fire && !wr_bias && hit)
        mem[wr_addr] <= wr_data;
      if (word_fire)
        rd <= mem[in_data];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prior <= '0;
        acc   <= '0;
      end else begin
        if (wr_fire && wr_bias && hit)
          prior <= wr_data;
        if (out_fire)
          acc <= '0;
        else if (rd_vld_q)
          acc <= sat_add(acc, rd);
        else if (state_q == S_BIAS)
          acc <= sat_add(acc, prior);
      end
    end

    assign acc_all[g] = acc;
  end

  // Argmax step. A strictly greater score replaces the best, so on a tie the
  // lower class index is kept. The tied score then becomes the second-best,
  // which gives a margin of 0.
  always_comb begin
    cur = '0;
    for (int unsigned c = 0; c < AMOUNT_CLASS; c++)
      if (scan_q == CW'(c)) cur = acc_all[c];
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (scan_q == '0) begin
      best_d     = cur;
      second_d   = ACC_MIN;
      best_idx_d = '0;
    end else if (cur > best_q) begin
      second_d   = best_q;
      best_d     = cur;
      best_idx_d = scan_q;
    end else if (cur > second_q) begin
      second_d   = cur;
    end
    // best >= second, so the difference fits in WIDTH_ACC unsigned bits.
    diff     = {best_d[WIDTH_ACC-1], best_d} - {second_d[WIDTH_ACC-1], second_d};
    margin_d = (AMOUNT_CLASS == 1) ? '1 : diff[WIDTH_ACC-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_fire) state_d = (in_data == '0) ? S_BIAS : S_ACCUM;
      S_ACCUM: if (in_fire && cnt_q == WIDTH_WORD'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_BIAS;
      S_BIAS:  state_d = S_SCAN;
      S_SCAN:  if (scan_q == CW'(AMOUNT_CLASS - 1)) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      scan_q     <= '0;
      rd_vld_q   <= 1'b0;
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      class_win  <= '0;
      score_win  <= '0;
      margin     <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= word_fire;
      if (in_fire && state_q == S_IDLE)
        cnt_q <= in_data;
      else if (word_fire)
        cnt_q <= cnt_q - WIDTH_WORD'(1);
      if (state_q == S_BIAS)
        scan_q <= '0;
      else if (state_q == S_SCAN) begin
        scan_q     <= scan_q + CW'(1);
        best_q     <= best_d;
        second_q   <= second_d;
        best_idx_q <= best_idx_d;
        if (scan_q == CW'(AMOUNT_CLASS - 1)) begin
          class_win <= best_idx_d;
          score_win <= best_d;
          margin    <= margin_d;
        end
      end
    end
  end

endmodule
